// File: rtl/pc_seq_if.sv
// Decoder-side bundle for the picoMIPS program counter.
// The decoder is the master; pc_seq is the slave.
interface pc_seq_if #(
  parameter int Psize = 6
);
  logic             stall;
  logic [2:0]       op;
  logic [Psize-1:0] target;
  logic [Psize-1:0] offset;
  logic             cond;
  logic             resume;
  logic [Psize-1:0] PCout;
  logic             halted;
  logic             rs_empty;
  logic             rs_full;
  logic             rs_overflow;
  logic             rs_underflow;

  modport master (
    output stall, op, target, offset, cond, resume,
    input  PCout, halted, rs_empty, rs_full, rs_overflow, rs_underflow
  );

  modport slave (
    input  stall, op, target, offset, cond, resume,
    output PCout, halted, rs_empty, rs_full, rs_overflow, rs_underflow
  );
endinterface

// File: rtl/pc_seq.sv
// picoMIPS program counter: INC/JMP/branch/CALL/RET/HALT with a circular
// hardware return stack, stall, and sticky stack overflow/underflow flags.
module pc_seq #(
  parameter int Psize    = 6,
  parameter int RS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  pc_seq_if.slave  bus
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRT  = 3'b010;
  localparam logic [2:0] OP_BRF  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;

  localparam logic [CW-1:0] CNT_FULL = CW'(RS_DEPTH);

  logic [Psize-1:0] pc_q, pc_d;
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    tp_q, tp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [Psize-1:0] stack_q [RS_DEPTH];
  logic [Psize-1:0] stack_d [RS_DEPTH];

  logic [Psize-1:0] pc_inc_s;
  logic [Psize-1:0] pc_rel_s;
  logic [AW-1:0]    tp_dec_s;

  assign pc_inc_s = pc_q + Psize'(1);
  assign pc_rel_s = pc_q + bus.offset;
  assign tp_dec_s = tp_q - AW'(1);

  // Next-state logic; tp_q is the next write slot, so a push on a full
  // stack naturally overwrites the oldest entry.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    tp_d    = tp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    stack_d = stack_q;
    if (bus.stall) begin
      pc_d = pc_q;
    end else if (state_q == S_HALTED) begin
      if (bus.resume) begin
        state_d = S_RUN;
        pc_d    = pc_inc_s;
      end else begin
        pc_d = pc_q;
      end
    end else begin
      case (bus.op)
        OP_INC:  pc_d = pc_inc_s;
        OP_JMP:  pc_d = bus.target;
        OP_BRT:  pc_d = bus.cond ? pc_rel_s : pc_inc_s;
        OP_BRF:  pc_d = bus.cond ? pc_inc_s : pc_rel_s;
        OP_CALL: begin
          pc_d          = bus.target;
          stack_d[tp_q] = pc_inc_s;
          tp_d          = tp_q + AW'(1);
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_RET: begin
          if (cnt_q != CW'(0)) begin
            pc_d  = stack_q[tp_dec_s];
            tp_d  = tp_dec_s;
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = pc_inc_s;
            unf_d = 1'b1;
          end
        end
        OP_HALT: state_d = S_HALTED;
        default: pc_d = pc_inc_s;
      endcase
    end
  end

  // Control and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= Psize'(0);
      state_q <= S_RUN;
      cnt_q   <= CW'(0);
      tp_q    <= AW'(0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; its contents are meaningless at count 0.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.PCout        = pc_q;
  assign bus.halted       = (state_q == S_HALTED);
  assign bus.rs_empty     = (cnt_q == CW'(0));
  assign bus.rs_full      = (cnt_q == CNT_FULL);
  assign bus.rs_overflow  = ovf_q;
  assign bus.rs_underflow = unf_q;
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a queue-based reference model predicts each
// cycle's outputs; a monitor pops and compares one entry per clock edge.
module tb_pc_seq;
  localparam int PSIZE = 6;
  localparam int DEPTH = 4;
  localparam int PMOD  = 1 << PSIZE;

  typedef struct {
    int pc;
    bit h;
    bit e;
    bit f;
    bit o;
    bit u;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  int m_pc;
  int m_stk[$];
  bit m_halt;
  bit m_ovf;
  bit m_unf;

  pc_seq_if #(.Psize(PSIZE)) bus ();

  pc_seq #(.Psize(PSIZE), .RS_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t x;
    x.pc = m_pc;
    x.h  = m_halt;
    x.e  = (m_stk.size() == 0);
    x.f  = (m_stk.size() == DEPTH);
    x.o  = m_ovf;
    x.u  = m_unf;
    return x;
  endfunction

  task automatic model_reset();
    m_pc   = 0;
    m_stk  = {};
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle of inputs at the falling edge and predict the result.
  task automatic step(input logic [2:0] op, input int tgt, input int off,
                      input bit c, input bit st, input bit rs);
    @(negedge clk);
    bus.op     = op;
    bus.target = PSIZE'(tgt);
    bus.offset = PSIZE'(off);
    bus.cond   = c;
    bus.stall  = st;
    bus.resume = rs;
    if (!st) begin
      if (m_halt) begin
        if (rs) begin
          m_halt = 1'b0;
          m_pc   = (m_pc + 1) % PMOD;
        end
      end else begin
        case (op)
          3'd1: m_pc = tgt % PMOD;
          3'd2: m_pc = c ? (m_pc + off) % PMOD : (m_pc + 1) % PMOD;
          3'd3: m_pc = !c ? (m_pc + off) % PMOD : (m_pc + 1) % PMOD;
          3'd4: begin
            m_stk.push_back((m_pc + 1) % PMOD);
            if (m_stk.size() > DEPTH) begin
              void'(m_stk.pop_front());
              m_ovf = 1'b1;
            end
            m_pc = tgt % PMOD;
          end
          3'd5: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
              m_pc  = (m_pc + 1) % PMOD;
              m_unf = 1'b1;
            end
          end
          3'd6: m_halt = 1'b1;
          default: m_pc = (m_pc + 1) % PMOD;
        endcase
      end
    end
    sb.push_back(model_snapshot());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Reset pulsed between edges while a CALL is pending; it must not survive.
  task automatic do_reset();
    @(posedge clk);
    #3;
    bus.op     = 3'd4;
    bus.target = PSIZE'($urandom_range(0, PMOD - 1));
    bus.stall  = 1'b0;
    reset_n    = 1'b0;
    #1;
    cmp("rst_pc", 32'(bus.PCout), 32'd0);
    cmp("rst_halted", 32'(bus.halted), 32'd0);
    cmp("rst_empty", 32'(bus.rs_empty), 32'd1);
    cmp("rst_full", 32'(bus.rs_full), 32'd0);
    cmp("rst_ovf", 32'(bus.rs_overflow), 32'd0);
    cmp("rst_unf", 32'(bus.rs_underflow), 32'd0);
    model_reset();
    @(negedge clk);
    bus.stall = 1'b1;
    reset_n   = 1'b1;
    sb.push_back(model_snapshot());
  endtask

  // Monitor: every clock edge presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("pc", 32'(bus.PCout), 32'(e.pc));
        cmp("halted", 32'(bus.halted), 32'(e.h));
        cmp("rs_empty", 32'(bus.rs_empty), 32'(e.e));
        cmp("rs_full", 32'(bus.rs_full), 32'(e.f));
        cmp("rs_overflow", 32'(bus.rs_overflow), 32'(e.o));
        cmp("rs_underflow", 32'(bus.rs_underflow), 32'(e.u));
      end
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    bus.op     = 3'd0;
    bus.target = '0;
    bus.offset = '0;
    bus.cond   = 1'b0;
    bus.stall  = 1'b1;
    bus.resume = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    cmp("init_pc", 32'(bus.PCout), 32'd0);
    cmp("init_empty", 32'(bus.rs_empty), 32'd1);
    reset_n = 1'b1;
    sb.push_back(model_snapshot());

    for (int i = 0; i < 70; i++) step(3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("inc70_pc", 32'(bus.PCout), 32'd6);

    step(3'd1, 10, 0, 1'b0, 1'b0, 1'b0);
    step(3'd2, 0, 'h3C, 1'b1, 1'b0, 1'b0);
    settle();
    cmp("brt_taken", 32'(bus.PCout), 32'd6);
    step(3'd1, 10, 0, 1'b0, 1'b0, 1'b0);
    step(3'd2, 0, 'h3C, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("brt_not", 32'(bus.PCout), 32'd11);
    step(3'd1, 10, 0, 1'b0, 1'b0, 1'b0);
    step(3'd3, 0, 5, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("brf_taken", 32'(bus.PCout), 32'd15);
    step(3'd2, 0, 0, 1'b1, 1'b0, 1'b0);
    settle();
    cmp("brt_off0", 32'(bus.PCout), 32'd15);

    step(3'd1, 2, 0, 1'b0, 1'b0, 1'b0);
    step(3'd4, 20, 0, 1'b0, 1'b0, 1'b0);
    step(3'd4, 40, 0, 1'b0, 1'b0, 1'b0);
    step(3'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("nest_ret1", 32'(bus.PCout), 32'd21);
    step(3'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("nest_ret2", 32'(bus.PCout), 32'd3);
    cmp("nest_empty", 32'(bus.rs_empty), 32'd1);
    cmp("nest_ovf", 32'(bus.rs_overflow), 32'd0);

    step(3'd1, 1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) step(3'd4, 10 * i, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("ovf_full", 32'(bus.rs_full), 32'd1);
    cmp("ovf_flag", 32'(bus.rs_overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(3'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("ovf_last_ret", 32'(bus.PCout), 32'd11);
    cmp("ovf_empty", 32'(bus.rs_empty), 32'd1);

    do_reset();
    step(3'd1, 7, 0, 1'b0, 1'b0, 1'b0);
    step(3'd5, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("unf_pc", 32'(bus.PCout), 32'd8);
    cmp("unf_flag", 32'(bus.rs_underflow), 32'd1);
    for (int i = 0; i < 10; i++) step(3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("unf_sticky", 32'(bus.rs_underflow), 32'd1);

    for (int i = 0; i < 3; i++) step(3'd1, 30, 0, 1'b0, 1'b1, 1'b0);
    settle();
    cmp("stall_hold", 32'(bus.PCout), 32'd18);
    step(3'd1, 30, 0, 1'b0, 1'b0, 1'b0);
    step(3'd6, 0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    cmp("halt_pc", 32'(bus.PCout), 32'd30);
    cmp("halt_flag", 32'(bus.halted), 32'd1);
    step(3'd1, 5, 0, 1'b0, 1'b0, 1'b0);
    step(3'd0, 0, 0, 1'b0, 1'b1, 1'b1);
    step(3'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    settle();
    cmp("resume_pc", 32'(bus.PCout), 32'd31);
    cmp("resume_halted", 32'(bus.halted), 32'd0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(3'($urandom_range(0, 7)), int'($urandom_range(0, PMOD - 1)),
                int'($urandom_range(0, PMOD - 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    cmp("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
